// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM address/data, decode handshake and redirect request.
// The fetch unit uses the master modport; the ROM/decode/execute side uses slave.
interface instr_fetch_if;
   logic [31:0] imem_a;       // ROM byte address, data returns next cycle
   logic [31:0] imem_rd;      // ROM data for the address presented last cycle
   logic        if_valid;     // if_inst/if_pc hold a fetched instruction
   logic        if_ready;     // decode accepts this cycle
   logic [31:0] if_inst;      // instruction word
   logic [31:0] if_pc;        // byte address of if_inst
   logic        redirect;     // flush and restart at redirect_pc
   logic [31:0] redirect_pc;  // restart target, low two bits ignored

   modport master (
      output imem_a,
      input  imem_rd,
      output if_valid,
      input  if_ready,
      output if_inst,
      output if_pc,
      input  redirect,
      input  redirect_pc
   );

   modport slave (
      input  imem_a,
      output imem_rd,
      input  if_valid,
      output if_ready,
      input  if_inst,
      input  if_pc,
      output redirect,
      output redirect_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, addresses a synchronous ROM with one cycle of
// read latency and hands {instruction, PC} to decode over valid/ready. A single-entry
// skid buffer catches the word already returning from the ROM when decode stalls, so
// nothing is lost or duplicated. Redirects from execute flush and restart fetch.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master fetch
);

   // Next address to issue to the ROM.
   logic [31:0] pc_req_q, pc_req_d;
   // Address issued last cycle; its data is on imem_rd now.
   logic        inflight_v_q, inflight_v_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   // Word held back while decode stalls.
   logic        skid_v_q, skid_v_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   logic        skid_v_next;
   logic        issue;
   logic [31:0] redirect_tgt;

   assign redirect_tgt = fetch.redirect_pc & 32'hFFFF_FFFC;

   // The skid fills when a presented word is refused, and empties once decode takes it.
   assign skid_v_next = skid_v_q ? ~fetch.if_ready : (inflight_v_q & ~fetch.if_ready);

   // Only issue when the returning word has somewhere to go next cycle.
   assign issue = ~skid_v_next;

   // Output mux: skid contents take precedence over the word arriving from the ROM.
   always_comb begin
      fetch.if_inst  = skid_v_q ? skid_inst_q : fetch.imem_rd;
      fetch.if_pc    = skid_v_q ? skid_pc_q   : inflight_pc_q;
      // Nothing is offered while a flush or reset is in progress.
      fetch.if_valid = (skid_v_q | inflight_v_q) & ~fetch.redirect & ~rst;
      // Redirect target bypasses pc_req so the target word returns next cycle.
      fetch.imem_a   = fetch.redirect ? redirect_tgt : pc_req_q;
   end

   // Next-state: redirect flushes everything and issues the target, else normal flow.
   always_comb begin
      pc_req_d      = pc_req_q;
      inflight_v_d  = inflight_v_q;
      inflight_pc_d = inflight_pc_q;
      skid_v_d      = skid_v_q;
      skid_inst_d   = skid_inst_q;
      skid_pc_d     = skid_pc_q;

      if (fetch.redirect) begin
         skid_v_d      = 1'b0;
         inflight_v_d  = 1'b1;
         inflight_pc_d = redirect_tgt;
         pc_req_d      = redirect_tgt + PC_STEP;
      end else begin
         skid_v_d = skid_v_next;
         // Capture only on the fill transition; a full skid keeps its word.
         if (!skid_v_q && skid_v_next) begin
            skid_inst_d = fetch.imem_rd;
            skid_pc_d   = inflight_pc_q;
         end
         if (issue) begin
            inflight_v_d  = 1'b1;
            inflight_pc_d = pc_req_q;
            pc_req_d      = pc_req_q + PC_STEP;  // wraps modulo 2^32
         end else begin
            // Address is still driven but the returning data is ignored.
            inflight_v_d = 1'b0;
         end
      end
   end

   // Control state: synchronous reset drops skid and inflight and restarts at RESET_PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_req_q     <= RESET_PC;
         inflight_v_q <= 1'b0;
         skid_v_q     <= 1'b0;
      end else begin
         pc_req_q     <= pc_req_d;
         inflight_v_q <= inflight_v_d;
         skid_v_q     <= skid_v_d;
      end
   end

   // Datapath registers: qualified by the valid bits, so no reset needed.
   always_ff @(posedge clk) begin
      inflight_pc_q <= inflight_pc_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
   end

   // The skid only fills when issue stops, so both slots are never occupied at once.
   a_skid_inflight_exclusive : assert property (
      @(posedge clk) disable iff (rst) !(skid_v_q && inflight_v_q)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed reset/stall/redirect/reset-in-stall
// sequences, a wrap-around instance, and a randomized ready/redirect run, all compared
// against a stream model: the presented item is always the oldest unaccepted PC.
module tb_instr_fetch;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   instr_fetch_if bus ();
   instr_fetch_if bus2 ();

   instr_fetch #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .fetch (bus.master)
   );

   instr_fetch #(
      .RESET_PC (WRAP_PC),
      .PC_STEP  (32'd4)
   ) dut_wrap (
      .clk   (clk),
      .rst   (rst),
      .fetch (bus2.master)
   );

   // ROM image: four fixed words, a scrambled pattern elsewhere.
   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h0: rom = 32'h0430_0193;
         32'h4: rom = 32'h2030_00a3;
         32'h8: rom = 32'h2000_0083;
         32'hC: rom = 32'h0010_f093;
         default: rom = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // Synchronous ROMs, one cycle of latency.
   always @(posedge clk) begin
      bus.imem_rd  <= rom(bus.imem_a);
      bus2.imem_rd <= rom(bus2.imem_a);
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state for the main instance.
   logic        live;       // a word is expected to be presented this cycle
   logic [31:0] exp_pc;     // oldest PC not yet accepted by decode
   int          since_rst;  // cycles since reset release, for the wrap instance
   logic        chk_wrap;
   int          accepted;

   // One clock cycle: drive inputs, let them settle, check, then advance.
   task automatic run_cycle(input logic r, input logic rdy, input logic redir,
                            input logic [31:0] rpc);
      logic [31:0] tgt;
      rst              = r;
      bus.if_ready     = rdy;
      bus.redirect     = redir;
      bus.redirect_pc  = rpc;
      #2;
      tgt = rpc & 32'hFFFF_FFFC;
      if (r) begin
         check_eq("valid_in_reset", {31'd0, bus.if_valid}, 32'd0);
         live      = 1'b0;
         exp_pc    = 32'h0;
         since_rst = -1;
      end else if (redir) begin
         check_eq("valid_on_redirect", {31'd0, bus.if_valid}, 32'd0);
         check_eq("addr_on_redirect", bus.imem_a, tgt);
         live   = 1'b1;
         exp_pc = tgt;
      end else if (!live) begin
         check_eq("valid_after_reset", {31'd0, bus.if_valid}, 32'd0);
         check_eq("first_addr", bus.imem_a, exp_pc);
         live = 1'b1;
      end else begin
         check_eq("valid", {31'd0, bus.if_valid}, 32'd1);
         check_eq("pc", bus.if_pc, exp_pc);
         check_eq("inst", bus.if_inst, rom(exp_pc));
         // The next fetch address is always the one after the presented word.
         check_eq("next_addr", bus.imem_a, exp_pc + 32'd4);
         if (rdy) begin
            exp_pc = exp_pc + 32'd4;
            accepted++;
         end
      end

      // Wrap instance: always ready, expected PCs step from WRAP_PC through zero.
      if (chk_wrap && !r) begin
         if (since_rst == 0) begin
            check_eq("wrap_valid0", {31'd0, bus2.if_valid}, 32'd0);
         end else begin
            check_eq("wrap_valid", {31'd0, bus2.if_valid}, 32'd1);
            check_eq("wrap_pc", bus2.if_pc, WRAP_PC + 32'(4 * (since_rst - 1)));
            check_eq("wrap_inst", bus2.if_inst, rom(WRAP_PC + 32'(4 * (since_rst - 1))));
         end
      end
      since_rst++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst              = 1'b1;
      bus.if_ready     = 1'b1;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = 32'h0;
      bus2.if_ready    = 1'b1;
      bus2.redirect    = 1'b0;
      bus2.redirect_pc = 32'h0;
      live             = 1'b0;
      exp_pc           = 32'h0;
      since_rst        = 0;
      chk_wrap         = 1'b1;
      accepted         = 0;
      @(posedge clk);
      #1;

      // Reset then free-running fetch; the wrap instance runs alongside.
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk_wrap = 1'b0;

      // Stall while 0x4 is presented.
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Redirect to an unaligned target while the skid is full.
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_000B);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Reset in the middle of a stall, then refetch from zero.
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Randomized ready with occasional redirects.
      accepted = 0;
      for (int i = 0; i < 1000; i++) begin
         logic        rdy;
         logic        redir;
         logic [31:0] rpc;
         rdy   = 1'($urandom_range(0, 1));
         redir = ($urandom_range(0, 31) == 0);
         rpc   = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                          : $urandom;
         run_cycle(1'b0, rdy, redir, rpc);
      end
      check_eq("random_progress", {31'd0, accepted > 300}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
